load_store_unit: RTL and testbench
==================================

# load_store_unit

Bus initiator between the CPU datapath and the word-only memory interface. It accepts one load or store per request in byte, halfword or word size, and turns it into word-aligned memory transactions on the memory interface port. Sub-word stores are done as read-modify-write. Load results are sign- or zero-extended. The block has a single request/done handshake toward the core and holds mem_addr stable for every memory cycle.

## Interface
- XLEN, 32, data and address width (only 32 supported)
- clk  in  1  system clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- req  in  1  request strobe, sampled only in IDLE
- we  in  1  1 = store, 0 = load
- funct3  in  3  RISC-V size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address
- wdata  in  32  store data, low bytes used for B/H
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, transaction finished
- rdata  out  32  extended load result, held until next accept
- fault  out  1  valid with done: misaligned or illegal funct3
- mem_we  out  1  word write strobe to memory interface
- mem_addr  out  32  word-aligned address, bits [1:0] = 00
- mem_wd  out  32  write word
- mem_rd  in  32  read word, valid the cycle after mem_addr is driven

## Operation
- States: IDLE, ADDR, CAPT, WRITE, DONE.
- Accept: in IDLE with req=1, register we, funct3, addr, wdata. Move to the next state:
  - illegal funct3 or misaligned -> DONE with fault=1
  - load -> ADDR
  - store word -> WRITE
  - store B/H -> ADDR
- Illegal funct3: 011, 110, 111, or a store with funct3[2]=1.
- ADDR: drive mem_addr = {addr[31:2],2'b00}, then go to CAPT.
- CAPT: capture mem_rd into a word register. A load goes to DONE; a B/H store goes to WRITE.
- WRITE: mem_we=1 for exactly one cycle.
  - mem_wd = wdata for a word store.
  - For B/H, mem_wd = captured word with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0]. Byte lane = addr[1:0]; halfword lane = addr[1].
  - Next state is DONE.
- DONE: done=1. For loads, rdata = lane extracted from the captured word, sign-extended (000/001) or zero-extended (100/101). Next state is IDLE.
- Outside ADDR/CAPT/WRITE, mem_addr holds its last value. mem_we is 0 everywhere except WRITE.
- A req while busy is ignored, not queued. The core must hold its request fields until it observes busy.

## Timing
- Reset values: state IDLE; busy 0, done 0, fault 0, mem_we 0, rdata 0, mem_addr 0, mem_wd 0.
- Latency from the accept cycle T:
  - load: done at T+3
  - word store: done at T+2, mem_we at T+1
  - B/H store: done at T+4, mem_we at T+3
  - fault: done at T+1 with no memory cycle
- Back-to-back: the earliest next accept is the cycle after DONE, when state is IDLE.
- Reset mid-operation: state returns to IDLE immediately and mem_we deasserts asynchronously. No partial write is issued after reset, and no done pulse.
- fault and rdata are meaningful only while done=1. rdata keeps its previous value after a store or a fault.

## Configuration
- LSU_MISALIGN_TRAP_EN
  - Defined: an H access with addr[0]=1, or a W access with addr[1:0]!=0, raises fault and performs no memory access.
  - Undefined: no alignment check. Low address bits are truncated: H uses lane addr[1] with addr[0] ignored, and W ignores addr[1:0]. The access proceeds normally. Illegal-funct3 faults remain in both builds.

## Structure
- lsu_pkg holds:
  - state enum
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - helper constant for the word-align mask
- One sub-module, lsu_align, is combinational:
  - lane extract plus sign/zero extend for loads
  - lane merge for sub-word stores
  - the misalign and illegal-funct3 decode
- The FSM, registers and handshake stay in load_store_unit.

## Test plan
- LW, addr 0x0010_0008, memory word 0xDEADBEEF -> done at T+3, rdata 0xDEADBEEF, fault 0, mem_addr 0x0010_0008.
- LB and LBU, addr 0x0010_0003, same word -> rdata 0xFFFFFFDE for LB and 0x000000DE for LBU.
- SB, addr 0x0010_0001, wdata 0x000000AA, old word 0x11223344 -> a single mem_we pulse at T+3 with mem_wd 0x1122AA44, done at T+4.
- SW, addr 0x0010_0010, wdata 0xCAFEF00D -> mem_we at T+1 with mem_wd 0xCAFEF00D, done at T+2, no read cycle.
- LH, addr 0x0010_0001:
  - with LSU_MISALIGN_TRAP_EN, fault=1 at T+1 and mem_we never asserts
  - without it, rdata is taken from the lower halfword
- Reset asserted during WRITE of an SB -> mem_we drops the same cycle, state IDLE, busy 0, no done. A request after reset completes normally. funct3=011 -> fault at T+1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// The optional alignment trap is LSU_MISALIGN_TRAP_EN (see lsu_align).
package lsu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CAPT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return a & WORD_MASK;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/done handshake plus word memory bus of the LSU.
// slave = LSU side, master = core/memory side.
interface lsu_if;
  import lsu_pkg::*;

  logic            req;
  logic            we;
  logic [2:0]      funct3;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] rdata;
  logic            fault;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wd;
  logic [XLEN-1:0] mem_rd;

  modport slave (
    input  req,
    input  we,
    input  funct3,
    input  addr,
    input  wdata,
    input  mem_rd,
    output busy,
    output done,
    output rdata,
    output fault,
    output mem_we,
    output mem_addr,
    output mem_wd
  );

  modport master (
    output req,
    output we,
    output funct3,
    output addr,
    output wdata,
    output mem_rd,
    input  busy,
    input  done,
    input  rdata,
    input  fault,
    input  mem_we,
    input  mem_addr,
    input  mem_wd
  );

endinterface

// File: rtl/lsu_align.sv
// Lane extract/extend, sub-word merge and fault decode.
// LSU_MISALIGN_TRAP_EN enables the H/W alignment fault.
module lsu_align
  import lsu_pkg::*;
(
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [1:0]      lane,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] load_val,
  output logic [XLEN-1:0] store_val,
  output logic            fault
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  b;
  logic [15:0] h;
  logic        illegal;
  logic        misalign;

  // halfword lane ignores addr[0]
  assign bsh = {lane, 3'b000};
  assign hsh = {lane[1], 4'b0000};
  assign b   = word[bsh +: 8];
  assign h   = word[hsh +: 16];

  always_comb begin
    load_val = word;
    unique case (1'b1)
      (funct3 == F3_B):  load_val = {{24{b[7]}}, b};
      (funct3 == F3_H):  load_val = {{16{h[15]}}, h};
      (funct3 == F3_BU): load_val = {24'h0, b};
      (funct3 == F3_HU): load_val = {16'h0, h};
      default:           load_val = word;
    endcase
  end

  always_comb begin
    store_val = word;
    unique case (1'b1)
      (funct3 == F3_B): store_val[bsh +: 8] = wdata[7:0];
      (funct3 == F3_H): store_val[hsh +: 16] = wdata[15:0];
      (funct3 == F3_W): store_val = wdata;
      default:          store_val = word;
    endcase
  end

  assign illegal = (funct3 == 3'b011)
                 | (funct3[2:1] == 2'b11)
                 | (we & funct3[2]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((funct3[1:0] == 2'b01) & lane[0])
                  | ((funct3 == F3_W) & (lane != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign fault = illegal | misalign;

endmodule

// File: rtl/load_store_unit.sv
// Load/store bus initiator: word memory port, RMW sub-word stores.
// LSU_MISALIGN_TRAP_EN enables alignment faults for H/W accesses.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  lsu_if.slave  bus
);

  state_t state;
  state_t state_nx;

  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      lane_q;
  logic [XLEN-1:0] wdata_q;
  logic            fault_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [XLEN-1:0] mem_wd_q;

  logic            idle;
  logic            accept;
  logic            a_we;
  logic [2:0]      a_f3;
  logic [1:0]      a_lane;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] store_val;
  logic            flt;

  assign idle   = (state == S_IDLE);
  assign accept = idle & bus.req;

  // decode live request fields while idle, latched ones after
  assign a_we   = idle ? bus.we          : we_q;
  assign a_f3   = idle ? bus.funct3      : f3_q;
  assign a_lane = idle ? bus.addr[1:0]   : lane_q;

  lsu_align u_align (
    .we        (a_we),
    .funct3    (a_f3),
    .lane      (a_lane),
    .wdata     (wdata_q),
    .word      (bus.mem_rd),
    .load_val  (load_val),
    .store_val (store_val),
    .fault     (flt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (bus.req) begin
          if (flt)                        state_nx = S_DONE;
          else if (!bus.we)               state_nx = S_ADDR;
          else if (bus.funct3 == F3_W)    state_nx = S_WRITE;
          else                            state_nx = S_ADDR;
        end
      end
      S_ADDR:  state_nx = S_CAPT;
      S_CAPT:  state_nx = we_q ? S_WRITE : S_DONE;
      S_WRITE: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      lane_q     <= 2'b00;
      wdata_q    <= '0;
      fault_q    <= 1'b0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
    end else begin
      if (accept) begin
        we_q    <= bus.we;
        f3_q    <= bus.funct3;
        lane_q  <= bus.addr[1:0];
        wdata_q <= bus.wdata;
        fault_q <= flt;
        if (!flt) begin
          mem_addr_q <= word_align(bus.addr);
          if (bus.we && bus.funct3 == F3_W)
            mem_wd_q <= bus.wdata;
        end
      end
      // read word lands here: merge for stores, extend for loads
      if (state == S_CAPT) begin
        if (we_q) mem_wd_q <= store_val;
        else      rdata_q  <= load_val;
      end
    end
  end

  assign bus.busy     = ~idle;
  assign bus.done     = (state == S_DONE);
  assign bus.fault    = fault_q;
  assign bus.rdata    = rdata_q;
  assign bus.mem_we   = (state == S_WRITE);
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wd   = mem_wd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit.
// Follows LSU_MISALIGN_TRAP_EN to pick expected alignment behaviour.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk;
  logic rstn;
  logic [31:0] rd_word;

  lsu_if bus();

  assign bus.mem_rd = rd_word;

  load_store_unit dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs;
  int errs;

  int          done_at;
  int          done_cnt;
  int          we_at;
  int          we_cnt;
  logic [31:0] wd_seen;
  logic [31:0] wa_seen;
  logic [31:0] addr_k1;
  logic        fault_seen;
  logic [31:0] rdata_seen;

  // Issue one request and record what happens over 8 cycles.
  // Sample k is taken at the negedge in cycle T+k.
  task automatic issue(input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] old);
    rd_word = old;
    @(negedge clk);
    bus.req = 1'b1;
    bus.we = w;
    bus.funct3 = f3;
    bus.addr = a;
    bus.wdata = d;
    done_at = 0; done_cnt = 0; we_at = 0; we_cnt = 0;
    wd_seen = '0; wa_seen = '0; addr_k1 = '0;
    fault_seen = 1'b0; rdata_seen = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        addr_k1 = bus.mem_addr;
        bus.req = 1'b0;
      end
      if (bus.mem_we) begin
        we_cnt++;
        if (we_at == 0) we_at = k;
        wd_seen = bus.mem_wd;
        wa_seen = bus.mem_addr;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = k;
          fault_seen = bus.fault;
          rdata_seen = bus.rdata;
        end
      end
    end
  endtask

  task automatic test_reset;
    bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'b000;
    bus.addr = '0; bus.wdata = '0; rd_word = '0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL rst_done got %b want 0", bus.done); end
    vecs++; if (bus.mem_we !== 1'b0) begin errs++; $display("FAIL rst_mem_we got %b want 0", bus.mem_we); end
    vecs++; if (bus.fault !== 1'b0) begin errs++; $display("FAIL rst_fault got %b want 0", bus.fault); end
    vecs++; if (bus.rdata !== 32'h0) begin errs++; $display("FAIL rst_rdata got %h want 0", bus.rdata); end
    vecs++; if (bus.mem_addr !== 32'h0) begin errs++; $display("FAIL rst_mem_addr got %h want 0", bus.mem_addr); end
    vecs++; if (bus.mem_wd !== 32'h0) begin errs++; $display("FAIL rst_mem_wd got %h want 0", bus.mem_wd); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loads;
    issue(1'b0, F3_W, 32'h0010_0008, 32'h0, 32'hDEAD_BEEF);
    vecs++; if (done_at !== 3) begin errs++; $display("FAIL lw_done_at got %0d want 3", done_at); end
    vecs++; if (done_cnt !== 1) begin errs++; $display("FAIL lw_done_cnt got %0d want 1", done_cnt); end
    vecs++; if (rdata_seen !== 32'hDEAD_BEEF) begin errs++; $display("FAIL lw_rdata got %h want deadbeef", rdata_seen); end
    vecs++; if (fault_seen !== 1'b0) begin errs++; $display("FAIL lw_fault got %b want 0", fault_seen); end
    vecs++; if (addr_k1 !== 32'h0010_0008) begin errs++; $display("FAIL lw_mem_addr got %h want 00100008", addr_k1); end
    vecs++; if (we_cnt !== 0) begin errs++; $display("FAIL lw_we_cnt got %0d want 0", we_cnt); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL lw_busy_after got %b want 0", bus.busy); end

    issue(1'b0, F3_B, 32'h0010_0003, 32'h0, 32'hDEAD_BEEF);
    vecs++; if (rdata_seen !== 32'hFFFF_FFDE) begin errs++; $display("FAIL lb_rdata got %h want ffffffde", rdata_seen); end
    vecs++; if (addr_k1 !== 32'h0010_0000) begin errs++; $display("FAIL lb_mem_addr got %h want 00100000", addr_k1); end
    issue(1'b0, F3_BU, 32'h0010_0003, 32'h0, 32'hDEAD_BEEF);
    vecs++; if (rdata_seen !== 32'h0000_00DE) begin errs++; $display("FAIL lbu_rdata got %h want 000000de", rdata_seen); end
    issue(1'b0, F3_H, 32'h0010_0002, 32'h0, 32'hDEAD_BEEF);
    vecs++; if (rdata_seen !== 32'hFFFF_DEAD) begin errs++; $display("FAIL lh_hi_rdata got %h want ffffdead", rdata_seen); end
    issue(1'b0, F3_HU, 32'h0010_0002, 32'h0, 32'hDEAD_BEEF);
    vecs++; if (rdata_seen !== 32'h0000_DEAD) begin errs++; $display("FAIL lhu_rdata got %h want 0000dead", rdata_seen); end
    issue(1'b0, F3_H, 32'h0010_0000, 32'h0, 32'h1234_7F01);
    vecs++; if (rdata_seen !== 32'h0000_7F01) begin errs++; $display("FAIL lh_pos_rdata got %h want 00007f01", rdata_seen); end
    issue(1'b0, F3_B, 32'h0010_0001, 32'h0, 32'h1234_7F81);
    vecs++; if (rdata_seen !== 32'h0000_007F) begin errs++; $display("FAIL lb_pos_rdata got %h want 0000007f", rdata_seen); end
  endtask

  task automatic test_stores;
    issue(1'b1, F3_B, 32'h0010_0001, 32'h0000_00AA, 32'h1122_3344);
    vecs++; if (we_at !== 3) begin errs++; $display("FAIL sb_we_at got %0d want 3", we_at); end
    vecs++; if (we_cnt !== 1) begin errs++; $display("FAIL sb_we_cnt got %0d want 1", we_cnt); end
    vecs++; if (wd_seen !== 32'h1122_AA44) begin errs++; $display("FAIL sb_mem_wd got %h want 1122aa44", wd_seen); end
    vecs++; if (wa_seen !== 32'h0010_0000) begin errs++; $display("FAIL sb_mem_addr got %h want 00100000", wa_seen); end
    vecs++; if (done_at !== 4) begin errs++; $display("FAIL sb_done_at got %0d want 4", done_at); end
    vecs++; if (rdata_seen !== 32'h0000_007F) begin errs++; $display("FAIL sb_rdata_kept got %h want 0000007f", rdata_seen); end

    issue(1'b1, F3_H, 32'h0010_0002, 32'h0000_5566, 32'h1122_3344);
    vecs++; if (wd_seen !== 32'h5566_3344) begin errs++; $display("FAIL sh_mem_wd got %h want 55663344", wd_seen); end
    vecs++; if (done_at !== 4) begin errs++; $display("FAIL sh_done_at got %0d want 4", done_at); end

    issue(1'b1, F3_W, 32'h0010_0010, 32'hCAFE_F00D, 32'h0);
    vecs++; if (we_at !== 1) begin errs++; $display("FAIL sw_we_at got %0d want 1", we_at); end
    vecs++; if (we_cnt !== 1) begin errs++; $display("FAIL sw_we_cnt got %0d want 1", we_cnt); end
    vecs++; if (wd_seen !== 32'hCAFE_F00D) begin errs++; $display("FAIL sw_mem_wd got %h want cafef00d", wd_seen); end
    vecs++; if (wa_seen !== 32'h0010_0010) begin errs++; $display("FAIL sw_mem_addr got %h want 00100010", wa_seen); end
    vecs++; if (done_at !== 2) begin errs++; $display("FAIL sw_done_at got %0d want 2", done_at); end
    vecs++; if (fault_seen !== 1'b0) begin errs++; $display("FAIL sw_fault got %b want 0", fault_seen); end
  endtask

  task automatic test_faults;
    issue(1'b0, 3'b011, 32'h0010_0000, 32'h0, 32'h0);
    vecs++; if (done_at !== 1) begin errs++; $display("FAIL f011_done_at got %0d want 1", done_at); end
    vecs++; if (fault_seen !== 1'b1) begin errs++; $display("FAIL f011_fault got %b want 1", fault_seen); end
    vecs++; if (done_cnt !== 1) begin errs++; $display("FAIL f011_done_cnt got %0d want 1", done_cnt); end

    issue(1'b1, F3_BU, 32'h0010_0000, 32'hFF, 32'h0);
    vecs++; if (fault_seen !== 1'b1) begin errs++; $display("FAIL sbu_fault got %b want 1", fault_seen); end
    vecs++; if (we_cnt !== 0) begin errs++; $display("FAIL sbu_we_cnt got %0d want 0", we_cnt); end
    vecs++; if (rdata_seen !== 32'h0000_007F) begin errs++; $display("FAIL sbu_rdata_kept got %h want 0000007f", rdata_seen); end

    issue(1'b0, 3'b111, 32'h0010_0000, 32'h0, 32'h0);
    vecs++; if (fault_seen !== 1'b1) begin errs++; $display("FAIL f111_fault got %b want 1", fault_seen); end
  endtask

  task automatic test_misalign;
    issue(1'b0, F3_H, 32'h0010_0001, 32'h0, 32'hDEAD_BEEF);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs++; if (done_at !== 1) begin errs++; $display("FAIL lh_mis_done_at got %0d want 1", done_at); end
    vecs++; if (fault_seen !== 1'b1) begin errs++; $display("FAIL lh_mis_fault got %b want 1", fault_seen); end
`else
    vecs++; if (done_at !== 3) begin errs++; $display("FAIL lh_mis_done_at got %0d want 3", done_at); end
    vecs++; if (rdata_seen !== 32'hFFFF_BEEF) begin errs++; $display("FAIL lh_mis_rdata got %h want ffffbeef", rdata_seen); end
`endif
    vecs++; if (we_cnt !== 0) begin errs++; $display("FAIL lh_mis_we_cnt got %0d want 0", we_cnt); end

    issue(1'b1, F3_W, 32'h0010_0022, 32'h0BAD_CAFE, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs++; if (we_cnt !== 0) begin errs++; $display("FAIL sw_mis_we_cnt got %0d want 0", we_cnt); end
    vecs++; if (fault_seen !== 1'b1) begin errs++; $display("FAIL sw_mis_fault got %b want 1", fault_seen); end
`else
    vecs++; if (wa_seen !== 32'h0010_0020) begin errs++; $display("FAIL sw_mis_addr got %h want 00100020", wa_seen); end
    vecs++; if (wd_seen !== 32'h0BAD_CAFE) begin errs++; $display("FAIL sw_mis_wd got %h want 0badcafe", wd_seen); end
`endif
  endtask

  task automatic test_reset_mid_write;
    int seen_done;
    rd_word = 32'h1122_3344;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = F3_B;
    bus.addr = 32'h0010_0001; bus.wdata = 32'h0000_00AA;
    @(negedge clk);
    bus.req = 1'b0;
    repeat (2) @(negedge clk);
    vecs++; if (bus.mem_we !== 1'b1) begin errs++; $display("FAIL rmw_we_before got %b want 1", bus.mem_we); end
    #1 rstn = 1'b0;
    #1;
    vecs++; if (bus.mem_we !== 1'b0) begin errs++; $display("FAIL rmw_we_async got %b want 0", bus.mem_we); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rmw_busy got %b want 0", bus.busy); end
    seen_done = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.done || bus.mem_we) seen_done++;
    end
    rstn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (bus.done || bus.mem_we) seen_done++;
    end
    vecs++; if (seen_done !== 0) begin errs++; $display("FAIL rmw_no_done got %0d want 0", seen_done); end

    issue(1'b0, F3_W, 32'h0010_0008, 32'h0, 32'h0F0F_1234);
    vecs++; if (done_at !== 3) begin errs++; $display("FAIL post_rst_done_at got %0d want 3", done_at); end
    vecs++; if (rdata_seen !== 32'h0F0F_1234) begin errs++; $display("FAIL post_rst_rdata got %h want 0f0f1234", rdata_seen); end
  endtask

  task automatic test_back_to_back;
    int acc_done;
    int cyc;
    rd_word = 32'hA5A5_5A5A;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = F3_W;
    bus.addr = 32'h0010_0004; bus.wdata = '0;
    acc_done = 0;
    cyc = 0;
    while (acc_done < 2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.done) acc_done++;
    end
    bus.req = 1'b0;
    vecs++; if (cyc !== 7) begin errs++; $display("FAIL b2b_cycles got %0d want 7", cyc); end
    vecs++; if (bus.rdata !== 32'hA5A5_5A5A) begin errs++; $display("FAIL b2b_rdata got %h want a5a55a5a", bus.rdata); end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_loads();
    test_stores();
    test_faults();
    test_misalign();
    test_reset_mid_write();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
